// File: rtl/mem_ctl_pkg.sv
// Control-code encodings, FSM state encoding and size decode shared by the
// read/write control mux and the data-memory access stage.
package mem_ctl_pkg;

   localparam logic [1:0] CTL_BYTE = 2'd0;
   localparam logic [1:0] CTL_HALF = 2'd1;
   localparam logic [1:0] CTL_WORD = 2'd2;
   localparam logic [1:0] CTL_NONE = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [2:0] size_from_code(input logic [1:0] code);
      logic [2:0] sz;
      case (code)
         CTL_BYTE: sz = 3'd1;
         CTL_HALF: sz = 3'd2;
         CTL_WORD: sz = 3'd4;
         default:  sz = 3'd1;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/mem_decoder_fsm_if.sv
// Command/response bundle between the control mux side (master) and the
// memory access stage (slave).
interface mem_decoder_fsm_if #(
   parameter int ADDR_W = 32
);
   logic [1:0]        memdecoderreadcontrol;
   logic [1:0]        memdecoderwritecontrol;
   logic              wrcheck;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              busy;
   logic              done;
   logic              err;
   logic              wrcheck_out;

   modport master (
      output memdecoderreadcontrol, memdecoderwritecontrol, wrcheck, addr, wdata,
      input  rdata, busy, done, err, wrcheck_out
   );

   modport slave (
      input  memdecoderreadcontrol, memdecoderwritecontrol, wrcheck, addr, wdata,
      output rdata, busy, done, err, wrcheck_out
   );
endinterface

// File: rtl/mem_decoder_fsm_byte_ram.sv
// Single-port byte-wide data memory: synchronous write, combinational read.
// Contents are deliberately not reset.
module byte_ram #(
   parameter int MEM_BYTES = 1024,
   parameter int AW        = $clog2(MEM_BYTES)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem_r [MEM_BYTES];

   // byte write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[addr] <= wdata;
      end
   end

   assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_decoder_fsm.sv
// Byte-serial load/store stage: validates a command in IDLE, then moves one
// byte per cycle between the latched operand and the internal byte RAM.
module mem_decoder_fsm
   import mem_ctl_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic            clk,
   input  logic            rst,
   mem_decoder_fsm_if.slave bus
);

   localparam int AW = $clog2(MEM_BYTES);
   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);

   state_t            state_r, state_nx_s;
   logic [AW-1:0]     addr_r, addr_nx_s;
   logic [2:0]        size_r, size_nx_s;
   logic [1:0]        cnt_r, cnt_nx_s;
   logic [DATA_W-1:0] wdata_r, wdata_nx_s;
   logic [DATA_W-1:0] rdata_r, rdata_nx_s;
   logic              wrc_lat_r, wrc_lat_nx_s;
   logic              err_r, err_nx_s;
   logic              wco_r, wco_nx_s;
   logic              busy_r, done_r;

   logic              rd_v_s, wr_v_s;
   logic [1:0]        sel_code_s;
   logic [2:0]        sel_size_s;
   logic              misaligned_s, out_of_range_s, reject_s, last_byte_s;
   logic [AW-1:0]     ram_addr_s;
   logic              ram_we_s;
   logic [7:0]        ram_wdata_s, ram_rdata_s;

   assign rd_v_s       = (bus.memdecoderreadcontrol  != CTL_NONE);
   assign wr_v_s       = (bus.memdecoderwritecontrol != CTL_NONE);
   assign sel_code_s   = rd_v_s ? bus.memdecoderreadcontrol : bus.memdecoderwritecontrol;
   assign sel_size_s   = size_from_code(sel_code_s);
   assign misaligned_s = ((sel_code_s == CTL_HALF) && bus.addr[0]) ||
                         ((sel_code_s == CTL_WORD) && (bus.addr[1:0] != 2'b00));
   // Extra top bit so addresses near 2**ADDR_W cannot wrap past the check
   assign out_of_range_s = (({1'b0, bus.addr} + {{(ADDR_W-2){1'b0}}, sel_size_s}) > MEM_LIMIT);
   assign reject_s     = (rd_v_s && wr_v_s) ||
                         ((rd_v_s || wr_v_s) && (misaligned_s || out_of_range_s));
   assign last_byte_s  = (({1'b0, cnt_r} + 3'd1) == size_r);

   assign ram_addr_s  = addr_r + AW'(cnt_r);
   assign ram_wdata_s = wdata_r[{cnt_r, 3'b000} +: 8];
   // A reset arriving mid-store must not commit the byte of that cycle
   assign ram_we_s    = (state_r == ST_WRITE) && !rst;

   byte_ram #(
      .MEM_BYTES (MEM_BYTES),
      .AW        (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we_s),
      .addr  (ram_addr_s),
      .wdata (ram_wdata_s),
      .rdata (ram_rdata_s)
   );

   // next-state and next-datapath decode
   always_comb begin
      state_nx_s   = state_r;
      addr_nx_s    = addr_r;
      size_nx_s    = size_r;
      cnt_nx_s     = cnt_r;
      wdata_nx_s   = wdata_r;
      rdata_nx_s   = rdata_r;
      wrc_lat_nx_s = wrc_lat_r;
      err_nx_s     = 1'b0;
      wco_nx_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (reject_s) begin
               state_nx_s = ST_DONE;
               err_nx_s   = 1'b1;
            end else if (rd_v_s) begin
               state_nx_s   = ST_READ;
               addr_nx_s    = bus.addr[AW-1:0];
               size_nx_s    = sel_size_s;
               wrc_lat_nx_s = bus.wrcheck;
               rdata_nx_s   = '0;
               cnt_nx_s     = 2'd0;
            end else if (wr_v_s) begin
               state_nx_s = ST_WRITE;
               addr_nx_s  = bus.addr[AW-1:0];
               size_nx_s  = sel_size_s;
               wdata_nx_s = bus.wdata;
               cnt_nx_s   = 2'd0;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_READ: begin
            rdata_nx_s[{cnt_r, 3'b000} +: 8] = ram_rdata_s;
            cnt_nx_s = cnt_r + 2'd1;
            if (last_byte_s) begin
               state_nx_s = ST_DONE;
               wco_nx_s   = wrc_lat_r;
            end else begin
               state_nx_s = ST_READ;
            end
         end
         ST_WRITE: begin
            cnt_nx_s = cnt_r + 2'd1;
            if (last_byte_s) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_WRITE;
            end
         end
         ST_DONE: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // state, datapath and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         addr_r    <= '0;
         size_r    <= 3'd0;
         cnt_r     <= 2'd0;
         wdata_r   <= '0;
         rdata_r   <= '0;
         wrc_lat_r <= 1'b0;
         err_r     <= 1'b0;
         wco_r     <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         addr_r    <= addr_nx_s;
         size_r    <= size_nx_s;
         cnt_r     <= cnt_nx_s;
         wdata_r   <= wdata_nx_s;
         rdata_r   <= rdata_nx_s;
         wrc_lat_r <= wrc_lat_nx_s;
         err_r     <= err_nx_s;
         wco_r     <= wco_nx_s;
         busy_r    <= (state_nx_s == ST_READ) || (state_nx_s == ST_WRITE);
         done_r    <= (state_nx_s == ST_DONE);
      end
   end

   assign bus.rdata       = rdata_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.err         = err_r;
   assign bus.wrcheck_out = wco_r;

endmodule

// File: tb/tb_mem_decoder_fsm.sv
// Directed-vector bench for mem_decoder_fsm: loads, stores, rejects,
// reset mid-store and back-to-back command timing.
module tb_mem_decoder_fsm;
   import mem_ctl_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   mem_decoder_fsm_if #(.ADDR_W(32)) bus ();

   mem_decoder_fsm #(
      .MEM_BYTES (1024),
      .ADDR_W    (32),
      .DATA_W    (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.memdecoderreadcontrol  = CTL_NONE;
      bus.memdecoderwritecontrol = CTL_NONE;
      bus.wrcheck = 1'b0;
      bus.addr    = 32'h0;
      bus.wdata   = 32'h0;
   endtask

   // Present a command for one edge, then wait (bounded) for done.
   // lat counts edges from the accepting edge to the edge raising done; -1 on timeout.
   task automatic run_cmd(input logic [1:0] rc, input logic [1:0] wc, input logic wrc,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output int busy_cnt);
      bus.memdecoderreadcontrol  = rc;
      bus.memdecoderwritecontrol = wc;
      bus.wrcheck = wrc;
      bus.addr    = a;
      bus.wdata   = wd;
      tick();
      idle_inputs();
      lat = 1;
      busy_cnt = 0;
      while (!bus.done && lat < 20) begin
         if (bus.busy) busy_cnt++;
         tick();
         lat++;
      end
      if (!bus.done) lat = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=%h", bus.rdata, 32'h0); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
      total++; if (bus.wrcheck_out !== 1'b0) begin bad++; $display("FAIL reset_wco got=%b exp=0", bus.wrcheck_out); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_word();
      int lat, bc;
      run_cmd(CTL_NONE, CTL_WORD, 1'b0, 32'h10, 32'hDEADBEEF, lat, bc);
      total++; if (lat !== 5) begin bad++; $display("FAIL st_word_lat got=%0d exp=5", lat); end
      total++; if (bc !== 4) begin bad++; $display("FAIL st_word_busy got=%0d exp=4", bc); end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL st_word_err got=%b exp=0", bus.err); end
      total++; if (bus.wrcheck_out !== 1'b0) begin bad++; $display("FAIL st_word_wco got=%b exp=0", bus.wrcheck_out); end
      tick();
      run_cmd(CTL_WORD, CTL_NONE, 1'b1, 32'h10, 32'h0, lat, bc);
      total++; if (lat !== 5) begin bad++; $display("FAIL ld_word_lat got=%0d exp=5", lat); end
      total++; if (bc !== 4) begin bad++; $display("FAIL ld_word_busy got=%0d exp=4", bc); end
      total++; if (bus.rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_word_data got=%h exp=%h", bus.rdata, 32'hDEADBEEF); end
      total++; if (bus.wrcheck_out !== 1'b1) begin bad++; $display("FAIL ld_word_wco got=%b exp=1", bus.wrcheck_out); end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL ld_word_err got=%b exp=0", bus.err); end
      tick();
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b exp=0", bus.done); end
   endtask

   task automatic test_subword();
      int lat, bc;
      run_cmd(CTL_BYTE, CTL_NONE, 1'b0, 32'h11, 32'h0, lat, bc);
      total++; if (lat !== 2) begin bad++; $display("FAIL ld_byte_lat got=%0d exp=2", lat); end
      total++; if (bus.rdata !== 32'h000000BE) begin bad++; $display("FAIL ld_byte_data got=%h exp=%h", bus.rdata, 32'h000000BE); end
      total++; if (bus.wrcheck_out !== 1'b0) begin bad++; $display("FAIL ld_byte_wco got=%b exp=0", bus.wrcheck_out); end
      tick();
      run_cmd(CTL_HALF, CTL_NONE, 1'b0, 32'h12, 32'h0, lat, bc);
      total++; if (lat !== 3) begin bad++; $display("FAIL ld_half_lat got=%0d exp=3", lat); end
      total++; if (bc !== 2) begin bad++; $display("FAIL ld_half_busy got=%0d exp=2", bc); end
      total++; if (bus.rdata !== 32'h0000DEAD) begin bad++; $display("FAIL ld_half_data got=%h exp=%h", bus.rdata, 32'h0000DEAD); end
      tick();
   endtask

   task automatic test_reject();
      int lat, bc;
      run_cmd(CTL_HALF, CTL_NONE, 1'b1, 32'h13, 32'h0, lat, bc);
      total++; if (lat !== 1) begin bad++; $display("FAIL rej_half_lat got=%0d exp=1", lat); end
      total++; if (bc !== 0) begin bad++; $display("FAIL rej_half_busy got=%0d exp=0", bc); end
      total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL rej_half_err got=%b exp=1", bus.err); end
      total++; if (bus.wrcheck_out !== 1'b0) begin bad++; $display("FAIL rej_half_wco got=%b exp=0", bus.wrcheck_out); end
      total++; if (bus.rdata !== 32'h0000DEAD) begin bad++; $display("FAIL rej_half_rdata got=%h exp=%h", bus.rdata, 32'h0000DEAD); end
      tick();
      run_cmd(CTL_WORD, CTL_NONE, 1'b0, 32'd1022, 32'h0, lat, bc);
      total++; if (lat !== 1) begin bad++; $display("FAIL rej_w1022_lat got=%0d exp=1", lat); end
      total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL rej_w1022_err got=%b exp=1", bus.err); end
      total++; if (bus.rdata !== 32'h0000DEAD) begin bad++; $display("FAIL rej_w1022_rdata got=%h exp=%h", bus.rdata, 32'h0000DEAD); end
      tick();
      run_cmd(CTL_NONE, CTL_WORD, 1'b0, 32'd1024, 32'h12345678, lat, bc);
      total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL rej_w1024_err got=%b exp=1", bus.err); end
      total++; if (bc !== 0) begin bad++; $display("FAIL rej_w1024_busy got=%0d exp=0", bc); end
      tick();
      run_cmd(CTL_BYTE, CTL_NONE, 1'b0, 32'hFFFF_FFFF, 32'h0, lat, bc);
      total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL rej_wrap_err got=%b exp=1", bus.err); end
      tick();
      run_cmd(CTL_NONE, CTL_BYTE, 1'b0, 32'd1023, 32'h0000005A, lat, bc);
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL st_last_err got=%b exp=0", bus.err); end
      tick();
      run_cmd(CTL_BYTE, CTL_NONE, 1'b0, 32'd1023, 32'h0, lat, bc);
      total++; if (bus.rdata !== 32'h0000005A) begin bad++; $display("FAIL ld_last_data got=%h exp=%h", bus.rdata, 32'h0000005A); end
      tick();
   endtask

   task automatic test_conflict();
      int lat, bc;
      run_cmd(CTL_NONE, CTL_WORD, 1'b0, 32'h20, 32'hCAFEF00D, lat, bc);
      tick();
      run_cmd(CTL_WORD, CTL_BYTE, 1'b1, 32'h20, 32'h00000000, lat, bc);
      total++; if (lat !== 1) begin bad++; $display("FAIL conflict_lat got=%0d exp=1", lat); end
      total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL conflict_err got=%b exp=1", bus.err); end
      total++; if (bus.wrcheck_out !== 1'b0) begin bad++; $display("FAIL conflict_wco got=%b exp=0", bus.wrcheck_out); end
      tick();
      run_cmd(CTL_WORD, CTL_NONE, 1'b0, 32'h20, 32'h0, lat, bc);
      total++; if (bus.rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL conflict_mem got=%h exp=%h", bus.rdata, 32'hCAFEF00D); end
      tick();
   endtask

   task automatic test_reset_mid();
      int lat, bc, dcnt;
      run_cmd(CTL_NONE, CTL_WORD, 1'b0, 32'h40, 32'h55667788, lat, bc);
      tick();
      bus.memdecoderwritecontrol = CTL_WORD;
      bus.addr  = 32'h40;
      bus.wdata = 32'h11223344;
      tick();
      idle_inputs();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
      total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL rstmid_rdata got=%h exp=0", bus.rdata); end
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.done) dcnt++;
         tick();
      end
      total++; if (dcnt !== 0) begin bad++; $display("FAIL rstmid_nodone got=%0d exp=0", dcnt); end
      run_cmd(CTL_WORD, CTL_NONE, 1'b0, 32'h40, 32'h0, lat, bc);
      total++; if (bus.rdata !== 32'h55663344) begin bad++; $display("FAIL rstmid_mem got=%h exp=%h", bus.rdata, 32'h55663344); end
      tick();
   endtask

   task automatic test_back_to_back();
      int lat, bc, dcnt;
      run_cmd(CTL_WORD, CTL_NONE, 1'b0, 32'h10, 32'h0, lat, bc);
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_first_done got=%b exp=1", bus.done); end
      bus.memdecoderreadcontrol = CTL_BYTE;
      bus.addr = 32'h10;
      tick();
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_ignored_in_done got=%b exp=0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_done_drop got=%b exp=0", bus.done); end
      tick();
      idle_inputs();
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_idle got=%b exp=1", bus.busy); end
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.done) dcnt++;
         tick();
      end
      total++; if (dcnt !== 1) begin bad++; $display("FAIL b2b_done_count got=%0d exp=1", dcnt); end
      total++; if (bus.rdata !== 32'h000000EF) begin bad++; $display("FAIL b2b_data got=%h exp=%h", bus.rdata, 32'h000000EF); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle_inputs();
      test_reset();
      test_word();
      test_subword();
      test_reject();
      test_conflict();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
